sha256_msg_padder: RTL and testbench

- Producer side of the SHA-256 message-schedule word interface.
- Accepts a raw message as a stream of MSB-first 32-bit words and emits complete 512-bit blocks, one word per handshake, as 16 consecutive words.
- Applies FIPS 180-4 padding: a 0x80 byte, zero fill, and the 64-bit big-endian bit length.
- The downstream round controller consumes the words and drives the chunk processor's data-valid strobe while m_valid and m_ready are both high.

---
 rtl/sha256_msg_padder.sv | 127 ++++++++++++
 tb/tb_sha256_msg_padder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: streams MSB-first message words and appends the 0x80 byte,
// zero fill and 64-bit bit length so that every message ends on a 16-word block boundary.
module sha256_msg_padder #(
   parameter int CNT_W = 61
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [31:0] s_data,
   input  logic        s_last,
   input  logic [2:0]  s_bytes,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [31:0] m_data,
   output logic        m_first,
   output logic        m_blk_end,
   output logic        m_msg_end,
   output logic        busy,
   output logic [2:0]  dbg_state
);

   typedef enum logic [2:0] {
      S_DATA   = 3'd0,
      S_PAD    = 3'd1,
      S_ZERO   = 3'd2,
      S_LEN_HI = 3'd3,
      S_LEN_LO = 3'd4
   } state_t;

   state_t           state, state_nxt;
   logic [3:0]       widx, widx_nxt;
   logic [CNT_W-1:0] count, count_nxt;
   logic [2:0]       k;
   logic [31:0]      last_word;
   logic [63:0]      bitlen;
   logic             hs;

   // Valid/ready: a word moves on a cycle where valid and ready are both high; valid
   // never waits for ready, and data/flags are held stable while valid is high and ready low.
   // In S_DATA the input is passed straight through, so s_ready mirrors m_ready.
   assign hs = m_ready && ((state != S_DATA) || s_valid);

   assign k      = (s_bytes > 3'd4) ? 3'd4 : s_bytes;
   assign bitlen = 64'({count, 3'b000});

   always_comb begin
      last_word = s_data;
      case (k)
         3'd0:    last_word = 32'h8000_0000;
         3'd1:    last_word = {s_data[31:24], 24'h80_0000};
         3'd2:    last_word = {s_data[31:16], 16'h8000};
         3'd3:    last_word = {s_data[31:8], 8'h80};
         default: last_word = s_data;
      endcase
   end

   always_comb begin
      state_nxt = state;
      widx_nxt  = widx;
      count_nxt = count;
      s_ready   = 1'b0;
      m_valid   = 1'b1;
      m_data    = 32'h0;
      case (state)
         S_DATA: begin
            m_valid = s_valid;
            s_ready = m_ready;
            m_data  = s_last ? last_word : s_data;
            if (hs) begin
               count_nxt = count + (s_last ? CNT_W'(k) : CNT_W'(4));
               if (s_last) begin
                  if (k == 3'd4)
                     state_nxt = S_PAD;
                  else
                     state_nxt = (widx == 4'd13) ? S_LEN_HI : S_ZERO;
               end
            end
         end
         S_PAD: begin
            m_data = 32'h8000_0000;
            if (hs) state_nxt = (widx == 4'd13) ? S_LEN_HI : S_ZERO;
         end
         S_ZERO: begin
            if (hs && widx == 4'd13) state_nxt = S_LEN_HI;
         end
         S_LEN_HI: begin
            m_data = bitlen[63:32];
            if (hs) state_nxt = S_LEN_LO;
         end
         S_LEN_LO: begin
            m_data = bitlen[31:0];
            if (hs) begin
               state_nxt = S_DATA;
               count_nxt = '0;
            end
         end
         default: state_nxt = S_DATA;
      endcase
      // S_LEN_LO sits at word 15, so the natural wrap returns widx to 0
      if (hs) widx_nxt = widx + 4'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_DATA;
         widx  <= '0;
         count <= '0;
      end else if (clear) begin
         state <= S_DATA;
         widx  <= '0;
         count <= '0;
      end else begin
         state <= state_nxt;
         widx  <= widx_nxt;
         count <= count_nxt;
      end
   end

   assign m_first   = m_valid && (widx == 4'd0);
   assign m_blk_end = m_valid && (widx == 4'd15);
   assign m_msg_end = (state == S_LEN_LO);
   assign busy      = (state != S_DATA) || (count != '0) || (widx != 4'd0);
   assign dbg_state = state;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: table of message lengths against a byte-level padding model,
// plus hand-written "abc", empty-message, clear and reset sequences.
module tb_sha256_msg_padder;

   logic        clk;
   logic        rst_n;
   logic        clear;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] s_data;
   logic        s_last;
   logic [2:0]  s_bytes;
   logic        m_valid;
   logic        m_ready = 1'b1;
   logic [31:0] m_data;
   logic        m_first;
   logic        m_blk_end;
   logic        m_msg_end;
   logic        busy;
   logic [2:0]  dbg_state;

   sha256_msg_padder #(.CNT_W(61)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last), .s_bytes(s_bytes),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .m_first(m_first), .m_blk_end(m_blk_end), .m_msg_end(m_msg_end),
      .busy(busy), .dbg_state(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          tests = 0;
   int          fails = 0;
   logic [34:0] exp_q[$];
   logic [7:0]  msg_q[$];
   logic        bp_en = 1'b0;
   logic        pad_phase = 1'b0;
   int          got_words = 0;
   int          msg_done = 0;
   logic [31:0] last_data = '0;
   logic        stalled = 1'b0;
   logic [31:0] held_data = '0;
   logic [34:0] e_word;

   typedef struct {
      int          nbytes;
      logic        bp;
      int          exp_words;
      logic [31:0] exp_len_lo;
   } vec_t;
   vec_t vecs[10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic first, input logic blk, input logic msg, input logic [31:0] d);
      exp_q.push_back({first, blk, msg, d});
   endtask

   // byte-level padding model over msg_q
   task automatic build_exp();
      logic [7:0]  p[$];
      logic [63:0] len;
      int          nw;
      p = msg_q;
      len = 64'(msg_q.size()) * 64'd8;
      p.push_back(8'h80);
      while (p.size() % 64 != 56) p.push_back(8'h00);
      for (int i = 7; i >= 0; i--) p.push_back(len[i*8 +: 8]);
      nw = p.size() / 4;
      for (int w = 0; w < nw; w++)
         push_exp(w % 16 == 0, w % 16 == 15, w == nw - 1,
                  {p[4*w], p[4*w+1], p[4*w+2], p[4*w+3]});
   endtask

   // m_ready driver
   always @(posedge clk) begin
      #1;
      m_ready = bp_en ? ($urandom_range(0, 99) < 55) : 1'b1;
   end

   // monitor / scoreboard
   always @(negedge clk) begin
      if (rst_n && !clear && m_valid) begin
         if (stalled) check("stall_data_stable", {32'h0, m_data}, {32'h0, held_data});
         if (pad_phase) check("pad_s_ready_low", {63'h0, s_ready}, 64'h0);
         if (m_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_word", {32'h0, m_data}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               e_word = exp_q.pop_front();
               check("word", {29'h0, m_first, m_blk_end, m_msg_end, m_data}, {29'h0, e_word});
            end
            got_words++;
            last_data = m_data;
            if (m_msg_end) msg_done++;
            stalled = 1'b0;
         end else begin
            stalled   = 1'b1;
            held_data = m_data;
         end
      end else begin
         stalled = 1'b0;
      end
   end

   // driver tasks
   task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
      logic hs;
      int   cyc;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      s_bytes = nb;
      hs  = 1'b0;
      cyc = 0;
      while (!hs && cyc < 200) begin
         @(negedge clk);
         hs = s_ready;
         @(posedge clk);
         #1;
         cyc++;
      end
      if (!hs) check("s_handshake_timeout", 64'h0, 64'h1);
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic send_msg();
      int          n;
      int          nw;
      int          start;
      int          cyc;
      logic [31:0] d;
      n  = msg_q.size();
      nw = (n == 0) ? 1 : (n + 3) / 4;
      start = msg_done;
      for (int w = 0; w < nw; w++) begin
         for (int b = 0; b < 4; b++)
            d[31-8*b -: 8] = (4*w + b < n) ? msg_q[4*w + b] : 8'hA5;
         if (w == nw - 1) send_word(d, 1'b1, 3'(n - 4*w));
         else             send_word(d, 1'b0, 3'($urandom_range(0, 7)));
      end
      pad_phase = 1'b1;
      cyc = 0;
      while (msg_done == start && cyc < 500) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      pad_phase = 1'b0;
      if (msg_done == start) check("msg_end_timeout", 64'h0, 64'h1);
      check("exp_q_drained", 64'(exp_q.size()), 64'h0);
   endtask

   task automatic send_abc();
      msg_q = {8'h61, 8'h62, 8'h63};
      push_exp(1'b1, 1'b0, 1'b0, 32'h6162_6380);
      for (int i = 1; i < 15; i++) push_exp(1'b0, 1'b0, 1'b0, 32'h0);
      push_exp(1'b0, 1'b1, 1'b1, 32'h0000_0018);
      got_words = 0;
      send_msg();
      check("abc_word_count", 64'(got_words), 64'd16);
   endtask

   task automatic send_partial();
      logic [31:0] d;
      for (int w = 0; w < 7; w++) begin
         d = $urandom();
         push_exp(w == 0, 1'b0, 1'b0, d);
         send_word(d, 1'b0, 3'd4);
      end
      check("partial_busy", {63'h0, busy}, 64'h1);
   endtask

   initial begin
      vecs[0] = '{0,   1'b0, 16, 32'h0000_0000};
      vecs[1] = '{3,   1'b0, 16, 32'h0000_0018};
      vecs[2] = '{52,  1'b0, 16, 32'h0000_01A0};
      vecs[3] = '{55,  1'b0, 16, 32'h0000_01B8};
      vecs[4] = '{56,  1'b0, 32, 32'h0000_01C0};
      vecs[5] = '{60,  1'b0, 32, 32'h0000_01E0};
      vecs[6] = '{63,  1'b0, 32, 32'h0000_01F8};
      vecs[7] = '{119, 1'b0, 32, 32'h0000_03B8};
      vecs[8] = '{130, 1'b0, 48, 32'h0000_0410};
      vecs[9] = '{130, 1'b1, 48, 32'h0000_0410};

      rst_n = 1'b0; clear = 1'b0; s_valid = 1'b0;
      s_data = 32'h1234_5678; s_last = 1'b0; s_bytes = 3'd0;
      #2;
      check("rst_m_valid", {63'h0, m_valid}, 64'h0);
      check("rst_busy", {63'h0, busy}, 64'h0);
      check("rst_m_first", {63'h0, m_first}, 64'h0);
      check("rst_m_msg_end", {63'h0, m_msg_end}, 64'h0);
      check("rst_m_data_passthru", {32'h0, m_data}, 64'h1234_5678);
      check("rst_s_ready", {63'h0, s_ready}, 64'h1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      send_abc();

      // empty message, hand-written
      msg_q.delete();
      push_exp(1'b1, 1'b0, 1'b0, 32'h8000_0000);
      for (int i = 1; i < 15; i++) push_exp(1'b0, 1'b0, 1'b0, 32'h0);
      push_exp(1'b0, 1'b1, 1'b1, 32'h0);
      send_msg();

      for (int v = 0; v < 10; v++) begin
         msg_q.delete();
         for (int i = 0; i < vecs[v].nbytes; i++) msg_q.push_back(8'($urandom_range(0, 255)));
         build_exp();
         got_words = 0;
         bp_en = vecs[v].bp;
         send_msg();
         bp_en = 1'b0;
         @(posedge clk); #1;
         check($sformatf("vec%0d_words", v), 64'(got_words), 64'(vecs[v].exp_words));
         check($sformatf("vec%0d_len_lo", v), {32'h0, last_data}, {32'h0, vecs[v].exp_len_lo});
         check($sformatf("vec%0d_idle", v), {63'h0, busy}, 64'h0);
      end

      // mid-message clear at widx 7
      send_partial();
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      check("clear_busy", {63'h0, busy}, 64'h0);
      check("clear_m_valid", {63'h0, m_valid}, 64'h0);
      check("clear_state", {61'h0, dbg_state}, 64'h0);
      send_abc();

      // mid-message asynchronous reset at widx 7
      send_partial();
      #2 rst_n = 1'b0;
      #1;
      check("areset_busy", {63'h0, busy}, 64'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("areset_m_first", {63'h0, m_first}, 64'h0);
      send_abc();

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
